// File: rtl/bot_seq_pkg.sv
// Shared types and constants for the Rojobot command sequencer.
package bot_seq_pkg;

  // Default tick-count width used by the packed command record.
  localparam int DUR_W = 8;

  // Motor-control value that halts both wheels.
  localparam logic [7:0] MOTCTL_STOP = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [7:0]       motctl;
    logic [DUR_W-1:0] ticks;
  } bot_cmd_t;

endpackage

// File: rtl/bot_cmd_sequencer_if.sv
// Command push channel between the GPIO register block and the sequencer.
interface bot_cmd_sequencer_if #(
  parameter int DUR_W = 8
);

  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [7:0]       i_cmd_motctl;
  logic [DUR_W-1:0] i_cmd_ticks;

  // Software side: offers commands.
  modport master (
    output i_cmd_valid,
    output i_cmd_motctl,
    output i_cmd_ticks,
    input  o_cmd_ready
  );

  // Sequencer side: accepts commands.
  modport slave (
    input  i_cmd_valid,
    input  i_cmd_motctl,
    input  i_cmd_ticks,
    output o_cmd_ready
  );

endinterface

// File: rtl/bot_cmd_fifo.sv
// Synchronous register-array FIFO with flush; head entry is visible on dout_o.
module bot_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [W-1:0]                 din_i,
  output logic [W-1:0]                 dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Flush overrides everything; push/pop are ignored when they cannot be honoured.
  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful behind valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/bot_cmd_sequencer.sv
// Replays queued timed motor commands onto the Rojobot MotCtl input and
// manages the update / completion interrupt flags.
module bot_cmd_sequencer
  import bot_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DUR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  bot_cmd_sequencer_if.slave         cmd_if,
  input  logic                       i_abort,
  input  logic                       i_upd,
  input  logic                       i_upd_ack,
  input  logic                       i_done_ack,
  output logic [7:0]                 o_motctl,
  output logic                       o_upd_flag,
  output logic                       o_done_irq,
  output logic                       o_aborted,
  output logic                       o_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW    = $clog2(DEPTH+1);
  localparam int CMD_W = 8 + DUR_W;

  seq_state_t       state_q, state_d;
  logic [7:0]       motctl_q, motctl_d;
  logic [DUR_W-1:0] remaining_q, remaining_d;
  logic             upd_q;
  logic             upd_flag_q, upd_flag_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             upd_edge;
  logic             cmd_ready;
  logic             cmd_push;
  logic             fifo_pop;
  logic             set_done;
  logic             set_abort;
  logic [CMD_W-1:0] fifo_din;
  logic [CMD_W-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       head_motctl;
  logic [DUR_W-1:0] head_ticks;

  // No bypass when full: a same-cycle pop never raises ready.
  assign cmd_ready          = !fifo_full && !i_abort;
  assign cmd_push           = cmd_if.i_cmd_valid && cmd_ready;
  assign cmd_if.o_cmd_ready = cmd_ready;

  assign fifo_din    = {cmd_if.i_cmd_motctl, cmd_if.i_cmd_ticks};
  assign head_motctl = fifo_dout[CMD_W-1 -: 8];
  assign head_ticks  = fifo_dout[DUR_W-1:0];

  assign upd_edge = i_upd & ~upd_q;

  bot_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_push),
    .pop_i   (fifo_pop),
    .flush_i (i_abort),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencer next-state, output value and sticky flag updates.
  always_comb begin
    state_d     = state_q;
    motctl_d    = motctl_q;
    remaining_d = remaining_q;
    upd_flag_d  = upd_flag_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    fifo_pop    = 1'b0;
    set_done    = 1'b0;
    set_abort   = 1'b0;

    if (i_abort) begin
      // Abort wins over everything; only flag it if there was work to cancel.
      state_d  = IDLE;
      motctl_d = MOTCTL_STOP;
      if ((state_q != IDLE) || !fifo_empty) begin
        set_done  = 1'b1;
        set_abort = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) state_d = LOAD;
        end
        LOAD: begin
          fifo_pop = 1'b1;
          if (head_ticks == '0) begin
            // Zero-length command: drop it without touching the motor value.
            if ((fifo_count > CW'(1)) || cmd_push) begin
              state_d = LOAD;
            end else begin
              motctl_d = MOTCTL_STOP;
              set_done = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            motctl_d    = head_motctl;
            remaining_d = head_ticks;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (upd_edge) begin
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == DUR_W'(1)) begin
              if (!fifo_empty) begin
                // Keep the current motor value through LOAD: no STOP glitch.
                state_d = LOAD;
              end else begin
                motctl_d = MOTCTL_STOP;
                set_done = 1'b1;
                state_d  = IDLE;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Acknowledges take priority over a coincident set.
    if (upd_edge)  upd_flag_d = 1'b1;
    if (i_upd_ack) upd_flag_d = 1'b0;

    if (set_done)  done_d    = 1'b1;
    if (set_abort) aborted_d = 1'b1;
    if (i_done_ack) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end
  end

  // State, output and flag registers. upd_q resets high so a level already
  // present at reset release is not mistaken for a fresh update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      motctl_q    <= MOTCTL_STOP;
      remaining_q <= '0;
      upd_q       <= 1'b1;
      upd_flag_q  <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      motctl_q    <= motctl_d;
      remaining_q <= remaining_d;
      upd_q       <= i_upd;
      upd_flag_q  <= upd_flag_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign o_motctl   = motctl_q;
  assign o_upd_flag = upd_flag_q;
  assign o_done_irq = done_q;
  assign o_aborted  = aborted_q;
  assign o_busy     = (state_q != IDLE) || !fifo_empty;
  assign o_count    = fifo_count;

endmodule

// File: tb/tb_bot_cmd_sequencer.sv
// Self-checking bench for bot_cmd_sequencer: motor values are scoreboarded
// in push order and checked whenever the DUT output changes.
`timescale 1ns/1ps
module tb_bot_cmd_sequencer;

  localparam int DEPTH  = 8;
  localparam int TDUR_W = 8;
  localparam int CW     = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_abort = 1'b0;
  logic          i_upd = 1'b0;
  logic          i_upd_ack = 1'b0;
  logic          i_done_ack = 1'b0;
  logic [7:0]    o_motctl;
  logic          o_upd_flag;
  logic          o_done_irq;
  logic          o_aborted;
  logic          o_busy;
  logic [CW-1:0] o_count;

  int n_vec = 0;
  int n_err = 0;
  int stop_cnt = 0;
  bit seen55 = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_motctl = 8'h00;

  bot_cmd_sequencer_if #(.DUR_W(TDUR_W)) cmd_if();

  bot_cmd_sequencer #(.DEPTH(DEPTH), .DUR_W(TDUR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_if     (cmd_if),
    .i_abort    (i_abort),
    .i_upd      (i_upd),
    .i_upd_ack  (i_upd_ack),
    .i_done_ack (i_done_ack),
    .o_motctl   (o_motctl),
    .o_upd_flag (o_upd_flag),
    .o_done_irq (o_done_irq),
    .o_aborted  (o_aborted),
    .o_busy     (o_busy),
    .o_count    (o_count)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: each new non-STOP motor value must be the next expected command.
  always @(negedge clk) begin
    if (!rst && (o_motctl !== prev_motctl)) begin
      if (o_motctl === 8'h55) seen55 = 1'b1;
      if (o_motctl === 8'h00) begin
        stop_cnt++;
      end else begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected motctl got %h want none queued", o_motctl);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (o_motctl !== e) begin
            n_err++;
            $display("FAIL sb_order motctl got %h want %h", o_motctl, e);
          end
        end
      end
    end
    prev_motctl = o_motctl;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic [7:0] m, input logic [7:0] t, output bit acc);
    cmd_if.i_cmd_valid  = 1'b1;
    cmd_if.i_cmd_motctl = m;
    cmd_if.i_cmd_ticks  = t;
    #1;
    acc = cmd_if.o_cmd_ready;
    if (acc && (t != 8'd0)) exp_q.push_back(m);
    @(posedge clk);
    #1;
    cmd_if.i_cmd_valid = 1'b0;
  endtask

  task automatic upd_pulse();
    i_upd = 1'b1;
    tick(1);
    i_upd = 1'b0;
    tick(2);
  endtask

  task automatic done_ack();
    i_done_ack = 1'b1;
    tick(1);
    i_done_ack = 1'b0;
  endtask

  task automatic wait_motctl(input logic [7:0] m, input string tag);
    int k = 0;
    while ((o_motctl !== m) && (k < 30)) begin
      tick(1);
      k++;
    end
    n_vec++;
    if (o_motctl !== m) begin
      n_err++;
      $display("FAIL %s timeout motctl got %h want %h", tag, o_motctl, m);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    i_upd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    n_vec++; if (o_motctl !== 8'h00) begin n_err++; $display("FAIL reset_motctl got %h want 00", o_motctl); end
    n_vec++; if (o_upd_flag !== 1'b0) begin n_err++; $display("FAIL reset_upd_high_flag got %b want 0", o_upd_flag); end
    n_vec++; if (o_done_irq !== 1'b0 || o_aborted !== 1'b0) begin n_err++; $display("FAIL reset_done got %b/%b want 0/0", o_done_irq, o_aborted); end
    n_vec++; if (o_busy !== 1'b0 || o_count !== '0) begin n_err++; $display("FAIL reset_busy_count got %b/%0d want 0/0", o_busy, o_count); end
    n_vec++; if (cmd_if.o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", cmd_if.o_cmd_ready); end
    i_upd = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    bit acc;
    push_cmd(8'h33, 8'd3, acc);
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL single_accept got %b want 1", acc); end
    n_vec++; if (o_motctl !== 8'h00 || o_count !== CW'(1)) begin n_err++; $display("FAIL single_n0 motctl/count got %h/%0d want 00/1", o_motctl, o_count); end
    tick(1);
    n_vec++; if (o_motctl !== 8'h00 || o_busy !== 1'b1) begin n_err++; $display("FAIL single_n1 motctl/busy got %h/%b want 00/1", o_motctl, o_busy); end
    tick(1);
    n_vec++; if (o_motctl !== 8'h33 || o_count !== '0) begin n_err++; $display("FAIL single_n2 motctl/count got %h/%0d want 33/0", o_motctl, o_count); end
    i_upd = 1'b1; tick(1); i_upd = 1'b0; tick(1);
    i_upd = 1'b1; tick(1); i_upd = 1'b0; tick(1);
    n_vec++; if (o_motctl !== 8'h33 || o_done_irq !== 1'b0) begin n_err++; $display("FAIL single_edge2 motctl/done got %h/%b want 33/0", o_motctl, o_done_irq); end
    i_upd = 1'b1; tick(1);
    n_vec++; if (o_motctl !== 8'h00 || o_done_irq !== 1'b1) begin n_err++; $display("FAIL single_edge3 motctl/done got %h/%b want 00/1", o_motctl, o_done_irq); end
    n_vec++; if (o_aborted !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL single_end aborted/busy got %b/%b want 0/0", o_aborted, o_busy); end
    i_upd = 1'b0;
    done_ack();
    n_vec++; if (o_done_irq !== 1'b0) begin n_err++; $display("FAIL single_ack done got %b want 0", o_done_irq); end
    n_vec++; if (o_upd_flag !== 1'b1) begin n_err++; $display("FAIL single_updflag got %b want 1", o_upd_flag); end
    i_upd_ack = 1'b1; tick(1); i_upd_ack = 1'b0;
    n_vec++; if (o_upd_flag !== 1'b0) begin n_err++; $display("FAIL single_updack got %b want 0", o_upd_flag); end
  endtask

  task automatic test_queue();
    bit acc;
    int stops0;
    logic [7:0] want [5];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h44; want[3] = 8'h44; want[4] = 8'h00;
    stops0 = stop_cnt;
    push_cmd(8'h11, 8'd2, acc);
    push_cmd(8'h22, 8'd1, acc);
    push_cmd(8'h44, 8'd2, acc);
    wait_motctl(8'h11, "queue_first");
    for (int p = 0; p < 5; p++) begin
      upd_pulse();
      n_vec++; if (o_motctl !== want[p]) begin n_err++; $display("FAIL queue_edge%0d motctl got %h want %h", p+1, o_motctl, want[p]); end
      n_vec++; if (o_done_irq !== (p == 4)) begin n_err++; $display("FAIL queue_done%0d got %b want %b", p+1, o_done_irq, (p == 4)); end
    end
    n_vec++; if (stop_cnt - stops0 !== 1) begin n_err++; $display("FAIL queue_stops got %0d want 1", stop_cnt - stops0); end
    done_ack();
    i_upd_ack = 1'b1; tick(1); i_upd_ack = 1'b0;
  endtask

  task automatic test_full();
    bit acc;
    int na = 0;
    for (int i = 0; i < 10; i++) begin
      push_cmd(8'hA0 + 8'(i), 8'd1, acc);
      if (acc) na++;
    end
    n_vec++; if (na !== 9) begin n_err++; $display("FAIL full_accepted got %0d want 9", na); end
    n_vec++; if (acc !== 1'b0) begin n_err++; $display("FAIL full_tenth got %b want 0", acc); end
    n_vec++; if (o_count !== CW'(8) || cmd_if.o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_count_ready got %0d/%b want 8/0", o_count, cmd_if.o_cmd_ready); end
    n_vec++; if (o_motctl !== 8'hA0) begin n_err++; $display("FAIL full_running got %h want a0", o_motctl); end
    i_abort = 1'b1; tick(1); i_abort = 1'b0;
    exp_q.delete();
    n_vec++; if (o_done_irq !== 1'b1 || o_aborted !== 1'b1 || o_count !== '0) begin n_err++; $display("FAIL full_flush got %b/%b/%0d want 1/1/0", o_done_irq, o_aborted, o_count); end
    done_ack();
  endtask

  task automatic test_abort();
    bit acc;
    for (int i = 0; i < 5; i++) push_cmd(8'hB0 + 8'(i), 8'd4, acc);
    n_vec++; if (o_motctl !== 8'hB0 || o_count !== CW'(4)) begin n_err++; $display("FAIL abort_pre motctl/count got %h/%0d want b0/4", o_motctl, o_count); end
    cmd_if.i_cmd_valid  = 1'b1;
    cmd_if.i_cmd_motctl = 8'h99;
    cmd_if.i_cmd_ticks  = 8'd2;
    i_abort = 1'b1;
    #1;
    n_vec++; if (cmd_if.o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready got %b want 0", cmd_if.o_cmd_ready); end
    @(posedge clk); #1;
    cmd_if.i_cmd_valid = 1'b0;
    i_abort = 1'b0;
    exp_q.delete();
    n_vec++; if (o_count !== '0 || o_motctl !== 8'h00) begin n_err++; $display("FAIL abort_out count/motctl got %0d/%h want 0/00", o_count, o_motctl); end
    n_vec++; if (o_done_irq !== 1'b1 || o_aborted !== 1'b1) begin n_err++; $display("FAIL abort_flags got %b/%b want 1/1", o_done_irq, o_aborted); end
    tick(4);
    n_vec++; if (o_count !== '0 || o_motctl !== 8'h00 || o_busy !== 1'b0) begin n_err++; $display("FAIL abort_dropped count/motctl/busy got %0d/%h/%b want 0/00/0", o_count, o_motctl, o_busy); end
    done_ack();
    n_vec++; if (o_done_irq !== 1'b0 || o_aborted !== 1'b0) begin n_err++; $display("FAIL abort_ack got %b/%b want 0/0", o_done_irq, o_aborted); end
    i_abort = 1'b1; tick(1); i_abort = 1'b0;
    n_vec++; if (o_done_irq !== 1'b0 || o_aborted !== 1'b0) begin n_err++; $display("FAIL abort_idle got %b/%b want 0/0", o_done_irq, o_aborted); end
  endtask

  task automatic test_upd_flag();
    bit acc;
    i_upd = 1'b1; tick(1); i_upd = 1'b0;
    n_vec++; if (o_upd_flag !== 1'b1) begin n_err++; $display("FAIL updf_set got %b want 1", o_upd_flag); end
    tick(1);
    i_upd_ack = 1'b1; tick(1); i_upd_ack = 1'b0;
    n_vec++; if (o_upd_flag !== 1'b0) begin n_err++; $display("FAIL updf_clear got %b want 0", o_upd_flag); end
    i_upd = 1'b1; i_upd_ack = 1'b1; tick(1); i_upd = 1'b0; i_upd_ack = 1'b0;
    n_vec++; if (o_upd_flag !== 1'b0) begin n_err++; $display("FAIL updf_ack_wins got %b want 0", o_upd_flag); end
    tick(1);
    upd_pulse();
    n_vec++; if (o_upd_flag !== 1'b1 || o_done_irq !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL updf_idle flag/done/busy got %b/%b/%b want 1/0/0", o_upd_flag, o_done_irq, o_busy); end
    push_cmd(8'h77, 8'd2, acc);
    wait_motctl(8'h77, "updf_load");
    upd_pulse();
    n_vec++; if (o_motctl !== 8'h77) begin n_err++; $display("FAIL updf_idle_uncounted got %h want 77", o_motctl); end
    upd_pulse();
    n_vec++; if (o_motctl !== 8'h00 || o_done_irq !== 1'b1) begin n_err++; $display("FAIL updf_finish got %h/%b want 00/1", o_motctl, o_done_irq); end
    done_ack();
    i_upd_ack = 1'b1; tick(1); i_upd_ack = 1'b0;
  endtask

  task automatic test_zero_tick();
    bit acc;
    push_cmd(8'h55, 8'd0, acc);
    push_cmd(8'h66, 8'd1, acc);
    wait_motctl(8'h66, "zero_load");
    n_vec++; if (o_done_irq !== 1'b0) begin n_err++; $display("FAIL zero_nodone got %b want 0", o_done_irq); end
    upd_pulse();
    n_vec++; if (o_motctl !== 8'h00 || o_done_irq !== 1'b1) begin n_err++; $display("FAIL zero_finish got %h/%b want 00/1", o_motctl, o_done_irq); end
    n_vec++; if (seen55 !== 1'b0) begin n_err++; $display("FAIL zero_never55 got %b want 0", seen55); end
    done_ack();
  endtask

  task automatic test_mid_reset();
    bit acc;
    push_cmd(8'hC3, 8'd5, acc);
    push_cmd(8'hC4, 8'd5, acc);
    wait_motctl(8'hC3, "mreset_load");
    i_upd = 1'b1; tick(1); i_upd = 1'b0;
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    n_vec++; if (o_motctl !== 8'h00 || o_count !== '0 || o_busy !== 1'b0) begin n_err++; $display("FAIL mreset_out got %h/%0d/%b want 00/0/0", o_motctl, o_count, o_busy); end
    n_vec++; if (o_upd_flag !== 1'b0 || o_done_irq !== 1'b0 || o_aborted !== 1'b0) begin n_err++; $display("FAIL mreset_flags got %b/%b/%b want 0/0/0", o_upd_flag, o_done_irq, o_aborted); end
    rst = 1'b0;
    tick(3);
    n_vec++; if (o_motctl !== 8'h00 || o_busy !== 1'b0) begin n_err++; $display("FAIL mreset_after got %h/%b want 00/0", o_motctl, o_busy); end
  endtask

  initial begin
    cmd_if.i_cmd_valid  = 1'b0;
    cmd_if.i_cmd_motctl = 8'h00;
    cmd_if.i_cmd_ticks  = 8'd0;
    test_reset();
    test_single();
    test_queue();
    test_full();
    test_abort();
    test_upd_flag();
    test_zero_tick();
    test_mid_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain leftover %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded bound");
    $fatal(1, "timeout");
  end

endmodule
